// File: rtl/psg_stereo_mixer.sv
// Stereo/mono mixer for three PSG channels: boxcar decimation over DECIM CE ticks,
// one-pole IIR smoothing, and a valid/ready output stage with a sticky overrun flag.
module psg_stereo_mixer #(
    parameter int DECIM    = 32,
    parameter int LP_SHIFT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [7:0]  CH_A,
    input  logic [7:0]  CH_B,
    input  logic [7:0]  CH_C,
    input  logic        STEREO,
    input  logic        OUT_READY,
    input  logic        CLR_OVR,
    output logic [15:0] AUDIO_L,
    output logic [15:0] AUDIO_R,
    output logic        OUT_VALID,
    output logic        OVERRUN
);

    localparam int CNT_W = $clog2(DECIM);
    localparam int ACC_W = 10 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_l, acc_r;
    logic [ACC_W-1:0] sum_l, sum_r;
    logic [9:0]       mix_l, mix_r;
    logic [9:0]       avg_l, avg_r;
    logic             pend;
    logic             window_close;
    logic             drop;
    logic [15:0]      y_l, y_r;
    logic [15:0]      y_next_l, y_next_r;

    // Signed difference keeps downward steps correct; shift is arithmetic.
    function automatic logic [15:0] lp_step(input logic [15:0] y, input logic [9:0] avg);
        logic signed [16:0] diff;
        logic signed [16:0] step;
        diff = $signed({1'b0, avg, 6'b000000}) - $signed({1'b0, y});
        step = diff >>> LP_SHIFT;
        return y + step[15:0];
    endfunction

    always_comb begin
        mix_l = '0;
        mix_r = '0;
        if (STEREO) begin
            mix_l = {1'b0, CH_A, 1'b0} + {2'b00, CH_B};
            mix_r = {1'b0, CH_C, 1'b0} + {2'b00, CH_B};
        end else begin
            mix_l = {2'b00, CH_A} + {2'b00, CH_B} + {2'b00, CH_C};
            mix_r = mix_l;
        end
    end

    assign sum_l        = acc_l + ACC_W'(mix_l);
    assign sum_r        = acc_r + ACC_W'(mix_r);
    assign window_close = CE && (cnt == CNT_LAST);
    assign y_next_l     = lp_step(y_l, avg_l);
    assign y_next_r     = lp_step(y_r, avg_r);
    assign drop         = pend && OUT_VALID && !OUT_READY;

    // Decimation window: the closing tick's mix is folded into the average directly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt   <= '0;
            acc_l <= '0;
            acc_r <= '0;
            avg_l <= '0;
            avg_r <= '0;
            pend  <= 1'b0;
        end else begin
            if (window_close) begin
                cnt   <= '0;
                acc_l <= '0;
                acc_r <= '0;
                avg_l <= sum_l[ACC_W-1:CNT_W];
                avg_r <= sum_r[ACC_W-1:CNT_W];
            end else if (CE) begin
                cnt   <= cnt + CNT_W'(1);
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
            if (window_close) begin
                pend <= 1'b1;
            end else if (pend) begin
                pend <= 1'b0;
            end
        end
    end

    // Filter always advances; the output register only takes the sample if it is free or being consumed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            y_l       <= '0;
            y_r       <= '0;
            AUDIO_L   <= '0;
            AUDIO_R   <= '0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (pend) begin
                y_l <= y_next_l;
                y_r <= y_next_r;
                if (!OUT_VALID || OUT_READY) begin
                    AUDIO_L   <= y_next_l;
                    AUDIO_R   <= y_next_r;
                    OUT_VALID <= 1'b1;
                end
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (drop) begin
                OVERRUN <= 1'b1;
            end else if (CLR_OVR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule
